// File: rtl/dsp_result_collector.sv
// rtl/dsp_result_collector.sv - tracks DSP start pulses through the pipeline latency and queues captured results
// Optional macro: DSP_RESULT_CHECK_EN adds model_out/err_count golden-result comparison.
module dsp_result_collector #(
    parameter int WIDTH            = 16,
    parameter int PIPE_STAGE_WIDTH = 2,
    parameter int BASE_LATENCY     = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        start,
    input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
    input  logic [2*WIDTH-1:0]          dsp_out,
    output logic [2*WIDTH-1:0]          res_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        overflow,
    output logic [15:0]                 res_count
`ifdef DSP_RESULT_CHECK_EN
    ,
    input  logic [2*WIDTH-1:0]          model_out,
    output logic [15:0]                 err_count
`endif
);

    localparam int TAG_LEN = BASE_LATENCY + 2**PIPE_STAGE_WIDTH - 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PW + 1;
    localparam int DW      = 2 * WIDTH;

    logic [TAG_LEN-1:0]          tag_q, tag_d;
    logic [PIPE_STAGE_WIDTH-1:0] lat_q, lat_d;
    logic [DW-1:0]               mem_q [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [DW-1:0]               res_data_q, res_data_d;
    logic                        overflow_q;
    logic [15:0]                 res_count_q;
    logic                        busy_c, cap, full, push, pop, drop;
    int                          tap_idx;

    // Tap position, busy and capture strobe from the current latency setting
    always_comb begin
        tap_idx = BASE_LATENCY - 1 + int'(lat_q);
        busy_c  = 1'b0;
        cap     = 1'b0;
        for (int k = 0; k < TAG_LEN; k++) begin
            if (k <= tap_idx) busy_c = busy_c | tag_q[k];
            if (k == tap_idx) cap = tag_q[k];
        end
    end

    // Tag shift: bits past the tap are dropped so a later latency change never resurrects them
    always_comb begin
        tag_d    = '0;
        tag_d[0] = start;
        for (int k = 1; k < TAG_LEN; k++) begin
            tag_d[k] = (k - 1 < tap_idx) ? tag_q[k-1] : 1'b0;
        end
        if (clr) tag_d = '0;
        // Latency follows pipe_stages while idle, including the first start (bypass)
        lat_d = busy_c ? lat_q : pipe_stages;
    end

    // FIFO control and next head value
    always_comb begin
        full       = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop        = res_valid && res_ready && !clr;
        push       = cap && !clr && (!full || pop);
        drop       = cap && !clr && full && !pop;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        res_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? dsp_out : mem_q[rd_ptr_d];
    end

    // Tag pipe and latency register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            lat_q <= '0;
        end else begin
            tag_q <= tag_d;
            lat_q <= lat_d;
        end
    end

    // FIFO storage; contents are qualified by the count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dsp_out;
    end

    // FIFO pointers, registered head, sticky overflow and accepted-capture counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            overflow_q  <= 1'b0;
            res_count_q <= '0;
        end else if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q   <= rd_ptr_d;
            res_data_q <= res_data_d;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) overflow_q <= 1'b1;
            if (push) res_count_q <= res_count_q + 16'd1;
        end
    end

`ifdef DSP_RESULT_CHECK_EN
    logic [15:0] err_count_q;

    // Saturating mismatch counter; dropped captures are still compared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (cap && !clr && (dsp_out != model_out) && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

    assign res_data  = res_data_q;
    assign res_valid = (cnt_q != '0);
    assign busy      = busy_c;
    assign overflow  = overflow_q;
    assign res_count = res_count_q;

endmodule
